// File: rtl/settings_pkg.sv
// Shared data-path settings for the shaper chain and the peak detector's state encoding.
package settings_pkg;

    localparam int FULL_SIZE        = 16;
    localparam int TS_WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TRACK   = 2'd1,
        HOLDOFF = 2'd2
    } peak_state_e;

endpackage

// File: rtl/trapez_shaper_result_intf.sv
// Shaper result stream plus the peak detector's configuration and event outputs.
interface trapez_shaper_result_intf
    import settings_pkg::*;
#(
    parameter int TS_WIDTH      = TS_WIDTH_DEFAULT,
    parameter int HOLDOFF_WIDTH = 16
);
    logic signed [FULL_SIZE-1:0] output_data;
    logic                        output_data_valid;
    logic signed [FULL_SIZE-1:0] threshold;
    logic [HOLDOFF_WIDTH-1:0]    holdoff;
    logic signed [FULL_SIZE-1:0] peak_data;
    logic [TS_WIDTH-1:0]         peak_time;
    logic                        peak_valid;
    logic                        pileup;
    logic                        busy;

    modport slave (
        input  output_data, output_data_valid, threshold, holdoff,
        output peak_data, peak_time, peak_valid, pileup, busy
    );

    modport master (
        output output_data, output_data_valid, threshold, holdoff,
        input  peak_data, peak_time, peak_valid, pileup, busy
    );
endinterface

// File: rtl/trapez_peak_detector_wrap.sv
// Binds the peak detector to the slave side of the shaper result interface.
module trapez_peak_detector_wrap
    import settings_pkg::*;
#(
    parameter int TS_WIDTH        = TS_WIDTH_DEFAULT,
    parameter int TIMEOUT_SAMPLES = 1024,
    parameter int HOLDOFF_WIDTH   = 16
) (
    input logic clk,
    input logic reset,
    trapez_shaper_result_intf.slave res
);

    trapez_peak_detector #(
        .TS_WIDTH        (TS_WIDTH),
        .TIMEOUT_SAMPLES (TIMEOUT_SAMPLES),
        .HOLDOFF_WIDTH   (HOLDOFF_WIDTH)
    ) u_det (
        .clk               (clk),
        .reset             (reset),
        .output_data       (res.output_data),
        .output_data_valid (res.output_data_valid),
        .threshold         (res.threshold),
        .holdoff           (res.holdoff),
        .peak_data         (res.peak_data),
        .peak_time         (res.peak_time),
        .peak_valid        (res.peak_valid),
        .pileup            (res.pileup),
        .busy              (res.busy)
    );

endmodule

// File: rtl/trapez_peak_detector.sv
// Extracts one pulse-height event (max, timestamp of first max, pile-up) per trapezoid
// from the shaper result stream.
module trapez_peak_detector
    import settings_pkg::*;
#(
    parameter int TS_WIDTH        = TS_WIDTH_DEFAULT,
    parameter int TIMEOUT_SAMPLES = 1024,
    parameter int HOLDOFF_WIDTH   = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic signed [FULL_SIZE-1:0] output_data,
    input  logic                        output_data_valid,
    input  logic signed [FULL_SIZE-1:0] threshold,
    input  logic [HOLDOFF_WIDTH-1:0]    holdoff,
    output logic signed [FULL_SIZE-1:0] peak_data,
    output logic [TS_WIDTH-1:0]         peak_time,
    output logic                        peak_valid,
    output logic                        pileup,
    output logic                        busy
);

    localparam int CNT_W = $clog2(TIMEOUT_SAMPLES + 1);
    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t CNT_ONE   = cnt_t'(1);
    localparam cnt_t CNT_LIMIT = cnt_t'(TIMEOUT_SAMPLES);
    localparam logic [HOLDOFF_WIDTH-1:0] HOLD_ONE  = HOLDOFF_WIDTH'(1);
    localparam logic [HOLDOFF_WIDTH-1:0] HOLD_ZERO = '0;
    localparam logic [TS_WIDTH-1:0]      TS_ONE    = TS_WIDTH'(1);

    peak_state_e                 state_q, state_d;
    logic [TS_WIDTH-1:0]         ts_q, ts_d;
    logic signed [FULL_SIZE-1:0] thr_q, thr_d;
    logic signed [FULL_SIZE-1:0] max_q, max_d;
    logic [TS_WIDTH-1:0]         max_ts_q, max_ts_d;
    logic                        falling_q, falling_d;
    logic                        pile_q, pile_d;
    cnt_t                        cnt_q, cnt_d;
    logic [HOLDOFF_WIDTH-1:0]    hold_q, hold_d;
    logic signed [FULL_SIZE-1:0] peak_data_q, peak_data_d;
    logic [TS_WIDTH-1:0]         peak_time_q, peak_time_d;
    logic                        peak_valid_q, peak_valid_d;
    logic                        pileup_q, pileup_d;
    logic                        busy_q;
    logic                        report;
    logic                        timed_out;

    always_comb begin
        state_d      = state_q;
        ts_d         = output_data_valid ? ts_q + TS_ONE : ts_q;
        thr_d        = thr_q;
        max_d        = max_q;
        max_ts_d     = max_ts_q;
        falling_d    = falling_q;
        pile_d       = pile_q;
        cnt_d        = cnt_q;
        hold_d       = hold_q;
        peak_data_d  = peak_data_q;
        peak_time_d  = peak_time_q;
        peak_valid_d = 1'b0;
        pileup_d     = pileup_q;
        report       = 1'b0;
        timed_out    = 1'b0;

        case (state_q)
            IDLE: begin
                if (output_data_valid && (output_data >= threshold)) begin
                    state_d   = TRACK;
                    thr_d     = threshold;
                    max_d     = output_data;
                    max_ts_d  = ts_q;
                    falling_d = 1'b0;
                    pile_d    = 1'b0;
                    cnt_d     = CNT_ONE;
                end
            end
            TRACK: begin
                if (output_data_valid) begin
                    if (output_data < thr_q) begin
                        report = 1'b1;
                    end else begin
                        // Strict compare keeps the first occurrence of an equal maximum.
                        if (output_data > max_q) begin
                            max_d    = output_data;
                            max_ts_d = ts_q;
                            if (falling_q) begin
                                pile_d = 1'b1;
                            end
                        end else if (output_data < max_q) begin
                            falling_d = 1'b1;
                        end
                        cnt_d = cnt_q + CNT_ONE;
                        if (cnt_d == CNT_LIMIT) begin
                            report    = 1'b1;
                            timed_out = 1'b1;
                        end
                    end
                end
            end
            HOLDOFF: begin
                if (hold_q == HOLD_ZERO) begin
                    state_d = IDLE;
                end else begin
                    hold_d = hold_q - HOLD_ONE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (report) begin
            peak_valid_d = 1'b1;
            peak_data_d  = max_d;
            peak_time_d  = max_ts_d;
            pileup_d     = pile_d | timed_out;
            hold_d       = holdoff;
            state_d      = (holdoff == HOLD_ZERO) ? IDLE : HOLDOFF;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            ts_q         <= '0;
            thr_q        <= '0;
            max_q        <= '0;
            max_ts_q     <= '0;
            falling_q    <= 1'b0;
            pile_q       <= 1'b0;
            cnt_q        <= '0;
            hold_q       <= '0;
            peak_data_q  <= '0;
            peak_time_q  <= '0;
            peak_valid_q <= 1'b0;
            pileup_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ts_q         <= ts_d;
            thr_q        <= thr_d;
            max_q        <= max_d;
            max_ts_q     <= max_ts_d;
            falling_q    <= falling_d;
            pile_q       <= pile_d;
            cnt_q        <= cnt_d;
            hold_q       <= hold_d;
            peak_data_q  <= peak_data_d;
            peak_time_q  <= peak_time_d;
            peak_valid_q <= peak_valid_d;
            pileup_q     <= pileup_d;
            busy_q       <= (state_d != IDLE);
        end
    end

    assign peak_data  = peak_data_q;
    assign peak_time  = peak_time_q;
    assign peak_valid = peak_valid_q;
    assign pileup     = pileup_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_trapez_peak_detector.sv
// Bench for trapez_peak_detector: table-driven sample streams with an event scoreboard.
module tb_trapez_peak_detector;
    import settings_pkg::*;

    localparam int TSW = 32;
    localparam int HW  = 16;
    localparam int TMO = 8;

    logic                        clk = 1'b0;
    logic                        reset = 1'b0;
    logic signed [FULL_SIZE-1:0] output_data = '0;
    logic                        output_data_valid = 1'b0;
    logic signed [FULL_SIZE-1:0] threshold = '0;
    logic [HW-1:0]               holdoff = '0;
    logic signed [FULL_SIZE-1:0] peak_data;
    logic [TSW-1:0]              peak_time;
    logic                        peak_valid;
    logic                        pileup;
    logic                        busy;

    trapez_peak_detector #(
        .TS_WIDTH        (TSW),
        .TIMEOUT_SAMPLES (TMO),
        .HOLDOFF_WIDTH   (HW)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .output_data       (output_data),
        .output_data_valid (output_data_valid),
        .threshold         (threshold),
        .holdoff           (holdoff),
        .peak_data         (peak_data),
        .peak_time         (peak_time),
        .peak_valid        (peak_valid),
        .pileup            (pileup),
        .busy              (busy)
    );

    trapez_shaper_result_intf #(.TS_WIDTH(TSW), .HOLDOFF_WIDTH(HW)) res_if ();
    assign res_if.output_data       = output_data;
    assign res_if.output_data_valid = output_data_valid;
    assign res_if.threshold         = threshold;
    assign res_if.holdoff           = holdoff;

    trapez_peak_detector_wrap #(
        .TS_WIDTH        (TSW),
        .TIMEOUT_SAMPLES (TMO),
        .HOLDOFF_WIDTH   (HW)
    ) wrap (
        .clk   (clk),
        .reset (reset),
        .res   (res_if.slave)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        bit rst;
        bit valid;
        int data;
        int thr;
        int hold;
        bit ev;
        int e_data;
        int e_time;
        bit e_pu;
    } vec_t;

    typedef struct {
        int     data;
        int     tm;
        bit     pu;
        longint cyc;
    } exp_t;

    vec_t   vecs[$];
    exp_t   exp_q[$];
    longint cyc = 0;
    int     checks = 0;
    int     errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, longint act, longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic add(bit rst, bit v, int d, int thr, int hold,
                       bit ev = 0, int ed = 0, int et = 0, bit ep = 0);
        vec_t r;
        r = '{rst, v, d, thr, hold, ev, ed, et, ep};
        vecs.push_back(r);
    endtask

    task automatic step(bit rst, bit v, int d, int thr, int hold,
                        bit ev = 0, int ed = 0, int et = 0, bit ep = 0);
        exp_t e;
        reset             = ~rst;
        output_data_valid = v;
        output_data       = d[FULL_SIZE-1:0];
        threshold         = thr[FULL_SIZE-1:0];
        holdoff           = hold[HW-1:0];
        if (ev) begin
            e = '{ed, et, ep, cyc + 1};
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every strobe (DUT or interface-bound copy) must match the next expected event.
    always @(negedge clk) begin
        exp_t e;
        if (peak_valid || res_if.peak_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", 1, 0);
            end else begin
                e = exp_q.pop_front();
                $display("event: data=%0d time=%0d pileup=%0b at cycle %0d", peak_data, peak_time, pileup, cyc);
                chk("strobe_cycle", cyc, e.cyc);
                chk("peak_valid", longint'(peak_valid), 1);
                chk("peak_data", longint'(peak_data), longint'(e.data));
                chk("peak_time", longint'(peak_time), longint'(e.tm));
                chk("pileup", longint'(pileup), longint'(e.pu));
                chk("wrap_peak_valid", longint'(res_if.peak_valid), 1);
                chk("wrap_peak_data", longint'(res_if.peak_data), longint'(e.data));
                chk("wrap_peak_time", longint'(res_if.peak_time), longint'(e.tm));
                chk("wrap_pileup", longint'(res_if.pileup), longint'(e.pu));
            end
        end
    end

    task automatic check_zero(string tag);
        chk({tag, "_peak_data"}, longint'(peak_data), 0);
        chk({tag, "_peak_time"}, longint'(peak_time), 0);
        chk({tag, "_peak_valid"}, longint'(peak_valid), 0);
        chk({tag, "_pileup"}, longint'(pileup), 0);
        chk({tag, "_busy"}, longint'(busy), 0);
        chk({tag, "_wrap_busy"}, longint'(res_if.busy), 0);
    endtask

    initial begin
        // Reset state
        step(1, 0, 0, 100, 0);
        step(1, 0, 0, 100, 0);
        check_zero("reset");

        // Single pulse, ts 0..6
        add(1, 0, 0, 100, 0);
        add(0, 1, 0, 100, 0);
        add(0, 1, 50, 100, 0);
        add(0, 1, 150, 100, 0);
        add(0, 1, 300, 100, 0);
        add(0, 1, 300, 100, 0);
        add(0, 1, 200, 100, 0);
        add(0, 1, 50, 100, 0, 1, 300, 3, 0);
        // Pile-up
        add(1, 0, 0, 100, 0);
        add(0, 1, 0, 100, 0);
        add(0, 1, 150, 100, 0);
        add(0, 1, 300, 100, 0);
        add(0, 1, 200, 100, 0);
        add(0, 1, 400, 100, 0);
        add(0, 1, 50, 100, 0, 1, 400, 4, 1);
        // Valid gaps: invalid cycles carry junk that must be ignored
        add(1, 0, 0, 100, 0);
        add(0, 1, 0, 100, 0);
        add(0, 0, 999, 100, 0);
        add(0, 1, 50, 100, 0);
        add(0, 0, 999, 100, 0);
        add(0, 1, 150, 100, 0);
        add(0, 0, 999, 100, 0);
        add(0, 1, 300, 100, 0);
        add(0, 0, 999, 100, 0);
        add(0, 1, 300, 100, 0);
        add(0, 0, 999, 100, 0);
        add(0, 1, 200, 100, 0);
        add(0, 0, 999, 100, 0);
        add(0, 1, 50, 100, 0, 1, 300, 3, 0);
        // Holdoff 5: terminating sample at ts2, re-arm at ts9
        add(1, 0, 0, 100, 5);
        add(0, 1, 0, 100, 5);
        add(0, 1, 200, 100, 5);
        add(0, 1, 50, 100, 5, 1, 200, 1, 0);
        add(0, 1, 0, 100, 5);
        add(0, 1, 0, 100, 5);
        add(0, 1, 0, 100, 5);
        add(0, 1, 200, 100, 5);
        add(0, 1, 200, 100, 5);
        add(0, 1, 400, 100, 5);
        add(0, 1, 300, 100, 5);
        add(0, 1, 50, 100, 5, 1, 300, 9, 0);
        for (int i = 0; i < 6; i++) add(0, 0, 0, 100, 5);
        // Threshold edge and latching: equal triggers, live change waits for IDLE
        add(1, 0, 0, 100, 0);
        add(0, 1, 99, 100, 0);
        add(0, 1, 100, 100, 0);
        add(0, 1, 120, 100, 0);
        add(0, 1, 110, 1000, 0);
        add(0, 1, 99, 1000, 0, 1, 120, 2, 0);
        add(0, 1, 500, 1000, 0);
        add(0, 1, 1200, 1000, 0);
        add(0, 1, 0, 1000, 0, 1, 1200, 6, 0);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].valid, vecs[i].data, vecs[i].thr, vecs[i].hold,
                 vecs[i].ev, vecs[i].e_data, vecs[i].e_time, vecs[i].e_pu);
        end

        // Timeout: constant 500, forced reports at ts7 and ts18, retrigger at ts11
        step(1, 0, 0, 100, 2);
        for (int i = 0; i < 20; i++) begin
            if (i == 7)       step(0, 1, 500, 100, 2, 1, 500, 0, 1);
            else if (i == 18) step(0, 1, 500, 100, 2, 1, 500, 11, 1);
            else              step(0, 1, 500, 100, 2);
        end
        for (int i = 0; i < 4; i++) step(0, 0, 0, 100, 0);

        // Reset mid-event after a completed report
        step(1, 0, 0, 100, 0);
        step(0, 1, 0, 100, 0);
        step(0, 1, 150, 100, 0);
        step(0, 1, 300, 100, 0);
        step(0, 1, 50, 100, 0, 1, 300, 2, 0);
        step(0, 1, 200, 100, 0);
        step(0, 1, 400, 100, 0);
        chk("track_busy", longint'(busy), 1);
        step(1, 1, 400, 100, 0);
        check_zero("midreset");
        step(0, 1, 0, 100, 0);
        step(0, 1, 50, 100, 0);
        step(0, 1, 150, 100, 0);
        step(0, 1, 300, 100, 0);
        step(0, 1, 300, 100, 0);
        step(0, 1, 200, 100, 0);
        step(0, 1, 50, 100, 0, 1, 300, 3, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 100, 0);

        chk("missing_strobes", longint'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/trapez_peak_detector.md
# trapez_peak_detector

Consumer on the output side of the trapezoidal shaper: takes the shaper's result stream (signed sample plus valid) and extracts one pulse-height event per trapezoid. For each event it reports the maximum amplitude, the sample-index timestamp of that maximum, and a pile-up flag. It feeds the downstream histogram/readout logic and is the slave on the shaper result signals.

## Interface
- `TS_WIDTH`, default 32: width of the sample-index timestamp.
- `TIMEOUT_SAMPLES`, default 1024: maximum number of valid above-threshold samples per event before a forced report.
- `HOLDOFF_WIDTH`, default 16: width of the holdoff input.
- Data width is `FULL_SIZE` from `settings_pkg`. It is not a parameter.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-low reset.
- `output_data` in `FULL_SIZE` signed: shaper result sample.
- `output_data_valid` in 1: sample qualifier.
- `threshold` in `FULL_SIZE` signed: trigger level, sampled while IDLE.
- `holdoff` in `HOLDOFF_WIDTH`: clock cycles of dead time after each report.
- `peak_data` out `FULL_SIZE` signed: event maximum.
- `peak_time` out `TS_WIDTH`: sample index of the first occurrence of the maximum.
- `peak_valid` out 1: one-cycle event strobe.
- `pileup` out 1: qualified by `peak_valid`.
- `busy` out 1: high in every state other than IDLE.

## Operation
- **Timestamp**
  - `ts` increments by 1 on every clock with `output_data_valid`=1, in all states.
  - Wraps modulo 2^`TS_WIDTH`.
  - The sample consumed with `ts`=n has index n.
- **States:** IDLE, TRACK, HOLDOFF.
- **IDLE**
  - A valid sample with `output_data` >= `threshold` (signed compare) moves to TRACK.
  - On entry: latch the threshold, set max=sample, set max_ts=ts, clear falling and pileup flags, set the sample count to 1.
- **TRACK** (valid samples only; invalid cycles change nothing)
  - sample < latched threshold: report and go to HOLDOFF.
  - sample > max: update max and max_ts. If falling=1, set pileup.
  - sample < max: set falling.
  - sample = max: no update, so the first occurrence of the maximum is kept.
  - Increment the sample count. When it reaches `TIMEOUT_SAMPLES`, report with pileup=1 and go to HOLDOFF.
- **Report**
  - `peak_data`, `peak_time` and `pileup` are registered.
  - `peak_valid`=1 for exactly one cycle.
  - Data outputs hold their value until the next report.
- **HOLDOFF**
  - Counts `holdoff` clock cycles regardless of valid. Samples are ignored but still advance `ts`.
  - Returns to IDLE after the count.
  - `holdoff`=0: report goes straight to IDLE.
- **Reset:** state IDLE, `ts`=0, all outputs 0. An event in progress is discarded with no strobe.

## Timing
- `peak_valid` rises on the edge that consumes the terminating sample (below threshold, or the `TIMEOUT_SAMPLES`-th sample).
- Latency: 1 cycle from the terminating sample to the strobe.
- IDLE re-arm:
  - HOLDOFF lasts exactly `holdoff` cycles after the strobe cycle.
  - The first sample eligible to retrigger is at strobe + `holdoff` + 1.
  - With `holdoff`=0, the sample in the cycle right after the terminating sample can trigger.
- `threshold` changes during TRACK or HOLDOFF take effect at the next IDLE.
- `busy` is registered with the state.

## Structure
- Add `TS_WIDTH` default and the state enum typedef (IDLE, TRACK, HOLDOFF) to `settings_pkg`.
- Ports map one-to-one onto the slave modport of `trapez_shaper_result_intf`.
- A top-level wrapper binds the interface.
- Single module. No sub-module is warranted: timestamp, counters and FSM are small.

## Test plan
- **Single pulse:** threshold 100, holdoff 0, valid every cycle, samples 0,50,150,300,300,200,50 at ts 0..6.
  - Expect one strobe in the cycle after ts 6: `peak_data`=300, `peak_time`=3, `pileup`=0.
- **Pile-up:** samples 0,150,300,200,400,50.
  - Expect `peak_data`=400, `peak_time`=4, `pileup`=1.
- **Timeout:** `TIMEOUT_SAMPLES`=8, constant 500 for 20 samples, holdoff 2.
  - Strobe after the 8th above-threshold sample, `pileup`=1.
  - Retrigger on the first sample after holdoff.
  - Second forced report after 8 more samples.
- **Holdoff:** holdoff 5.
  - A pulse starting 3 cycles after the strobe is ignored (no strobe).
  - A pulse starting 6 cycles after the strobe produces a strobe.
- **Valid gaps:** the single-pulse data with valid alternating 1/0.
  - Identical `peak_data`, `peak_time`=3, `pileup`=0.
- **Reset mid-event:** drive `reset`=0 for 1 cycle during TRACK.
  - All outputs 0, no strobe.
  - `ts` restarts at 0 and the next pulse is reported normally.
